// File: rtl/s_wallace_prod_acc.sv
// Streaming signed dot-product accumulator for 8-bit multiplier products, valid/ready in and out.
// Build option: define S_WALLACE_PROD_ACC_SAT_EN to clamp on overflow instead of wrapping.
module s_wallace_prod_acc #(
  parameter int unsigned ACC_W = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       prod,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned     EXT_W   = ACC_W - 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             accept;
  logic             load_out;
  logic             add_ovf;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W:0]   sum;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = in_last ? HOLD : ACC;
      ACC:  if (accept && in_last) state_d = HOLD;
      HOLD: begin
        if (accept)         state_d = in_last ? HOLD : ACC;
        else if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake and accumulate datapath; one extra sum bit exposes signed overflow
  always_comb begin
    in_ready = ~out_valid | out_ready;
    accept   = in_valid & in_ready;
    load_out = accept & in_last;
    prod_ext = {{EXT_W{prod[7]}}, prod};
    sum      = {acc_q[ACC_W-1], acc_q} + {prod_ext[ACC_W-1], prod_ext};
    add_ovf  = sum[ACC_W] ^ sum[ACC_W-1];
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (accept) begin
      if (state_q == ACC) begin
        acc_d = sum[ACC_W-1:0];
`ifdef S_WALLACE_PROD_ACC_SAT_EN
        if (add_ovf) acc_d = sum[ACC_W] ? ACC_MIN : ACC_MAX;
`endif
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        ovf_d = ovf_q | add_ovf;
      end else begin
        // IDLE or HOLD: this term opens a fresh vector
        acc_d = prod_ext;
        cnt_d = CNT_W'(1);
        ovf_d = 1'b0;
      end
    end
  end

  // Partial-sum registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Result registers load only when a vector closes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_acc   <= '0;
      out_cnt   <= '0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (load_out) begin
        out_acc   <= acc_d;
        out_cnt   <= cnt_d;
        out_ovf   <= ovf_d;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
